grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
Writer-side front end of the general register file. It merges two writeback sources into the single GRF write port, one write per cycle:
- the W-stage pipeline writeback, which never stalls;
- a long-latency result source (MDU/late load) with a valid/ready handshake.

Source-B requests are buffered in a small FIFO. Per-register busy flags go to the D-stage hazard unit so readers stall on queued writes.

Parameters:
DEPTH, 4, source-B FIFO entries (power of 2, 2..16)
CNT_W, 3, width of occupancy count; must satisfy 2^CNT_W > DEPTH

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
w_valid  in  1  W-stage writeback request; always accepted
w_addr  in  5  W-stage destination register
w_data  in  32  W-stage write data
w_pc  in  32  W-stage instruction PC (for write log)
b_valid  in  1  source-B request
b_ready  out  1  source-B may enqueue this cycle
b_addr  in  5  source-B destination register
b_data  in  32  source-B write data
b_pc  in  32  source-B instruction PC
wr_en  out  1  GRF write enable, registered
wr_addr  out  5  GRF write address, registered
wr_data  out  32  GRF write data, registered
wr_pc  out  32  PC of the write being committed, registered
rs_addr  in  5  D-stage read address 1
rt_addr  in  5  D-stage read address 2
rs_busy  out  1  rs_addr has a pending write (FIFO or wr stage)
rt_busy  out  1  rt_addr has a pending write
count  out  CNT_W  live (unsquashed and squashed) FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, all entries invalid, pointers 0.
  - wr_en=0, wr_addr=0, wr_data=0, wr_pc=0.
  - count=0, b_ready=0, rs_busy=rt_busy=0.
- Register 0:
  - Requests with addr=0 are accepted (w always; b when b_ready) but discarded.
  - They are never enqueued and never produce wr_en=1.
  - rs_busy/rt_busy are always 0 for address 0.
- Handshake:
  - b_ready = reset & (count < DEPTH), combinational.
  - An enqueue occurs at the edge where b_valid & b_ready.
  - A pop in the same cycle does not raise b_ready when full.
- Issue select, evaluated each cycle, registered at the rising edge:
  1. w_valid & w_addr!=0 → the W request is issued.
  2. Otherwise, if the FIFO is non-empty → the head is popped and issued, unless squashed.
  3. Otherwise → nothing is issued (wr_en=0 next cycle).
- Latency:
  - A request issued at edge N drives wr_en=1 for exactly one cycle after edge N.
  - The GRF commits it at edge N+1.
  - A source-B request enqueued into an empty FIFO with no W traffic is popped at the next edge: enqueue-to-wr_en latency is 2 edges.
- Squash (program-order rule, W is newer than any already-queued entry):
  - When a W request with address X issues, every valid FIFO entry with address X is marked squashed.
  - A squashed entry still occupies space and is still popped in order.
  - Popping a squashed entry produces wr_en=0 for that cycle.
- Simultaneous W issue and B enqueue to the same register: the B entry is newer and is NOT squashed.
- Simultaneous enqueue and pop: both take effect and count is unchanged.
- Busy flags (combinational):
  - rs_busy = (rs_addr!=0) & ((any valid unsquashed FIFO entry has addr==rs_addr) | (wr_en & wr_addr==rs_addr)).
  - rt_busy is the same with rt_addr.
- Ordering: FIFO entries to the same register commit strictly in enqueue order.
- Mid-operation reset: all queued and squashed entries are lost; wr_en drops to 0 immediately (async).

Test Plan:
- Reset release, then W requests addr 5/0x11111111 and addr 0/0xFFFFFFFF on consecutive cycles → one cycle with wr_en=1, wr_addr=5, wr_data=0x11111111; next cycle wr_en=0.
- Four B requests (regs 8,9,10,11; data 0xA0..0xA3) with w_valid held high on reg 3 → b_ready drops after the 4th (count=4); after w_valid drops, writes commit in order 8,9,10,11, one per cycle; b_ready returns when count<4.
- B enqueue reg 7/0xB7, then W issue to reg 7/0xC7 while the entry is still queued → wr_data=0xC7 for reg 7, the later pop gives wr_en=0; final reg 7 value 0xC7.
- Same cycle: W to reg 4/0x44 and B enqueue to reg 4/0x55 → commits 0x44 then 0x55; rs_addr=4 shows rs_busy=1 until the 0x55 write's wr_en cycle ends.
- Busy flags: queued reg 12, rs_addr=12, rt_addr=0 → rs_busy=1, rt_busy=0; squashing reg 12 via W → rs_busy stays 1 only during that W's wr_en cycle.
- Assert reset mid-burst with 3 entries queued → wr_en=0, count=0 immediately; after release, no queued write ever appears.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: W-stage writes always win, source-B results wait in a squashing FIFO.
// Issue at edge N drives wr_* for one cycle after N; source B is held off by b_ready when the FIFO is full.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             w_valid,
  input  logic [4:0]       w_addr,
  input  logic [31:0]      w_data,
  input  logic [31:0]      w_pc,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [4:0]       b_addr,
  input  logic [31:0]      b_data,
  input  logic [31:0]      b_pc,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [31:0]      wr_pc,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic             rs_busy,
  output logic             rt_busy,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic        vld;
    logic        sq;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } ent_t;

  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      wr_pc_q, wr_pc_d;
  logic             fifo_room, w_iss, b_enq, pop;
  logic             rs_hit, rt_hit;

  assign fifo_room = (cnt_q < CNT_W'(DEPTH));
  assign b_ready   = reset & fifo_room;
  assign w_iss     = w_valid & (w_addr != 5'd0);
  assign b_enq     = b_valid & fifo_room & (b_addr != 5'd0);
  assign pop       = ~w_iss & (cnt_q != '0);

  always_comb begin
    ent_d     = ent_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_pc_d   = wr_pc_q;

    if (w_iss) begin
      wr_en_d   = 1'b1;
      wr_addr_d = w_addr;
      wr_data_d = w_data;
      wr_pc_d   = w_pc;
      // W is younger than anything already queued, so older writes to its register are dead
      for (int i = 0; i < DEPTH; i++) begin
        if (ent_q[i].vld && (ent_q[i].addr == w_addr)) begin
          ent_d[i].sq = 1'b1;
        end
      end
    end else if (pop) begin
      wr_en_d = ~ent_q[rd_ptr_q].sq;
      if (!ent_q[rd_ptr_q].sq) begin
        wr_addr_d = ent_q[rd_ptr_q].addr;
        wr_data_d = ent_q[rd_ptr_q].data;
        wr_pc_d   = ent_q[rd_ptr_q].pc;
      end
      ent_d[rd_ptr_q] = '0;
      rd_ptr_d        = rd_ptr_q + PTR_W'(1);
    end

    // written after the squash loop so a same-cycle enqueue stays live
    if (b_enq) begin
      ent_d[wr_ptr_q] = '{vld: 1'b1, sq: 1'b0, addr: b_addr, data: b_data, pc: b_pc};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    case ({b_enq, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].vld && !ent_q[i].sq) begin
        if (ent_q[i].addr == rs_addr) rs_hit = 1'b1;
        if (ent_q[i].addr == rt_addr) rt_hit = 1'b1;
      end
    end
  end

  assign rs_busy = (rs_addr != 5'd0) & (rs_hit | (wr_en_q & (wr_addr_q == rs_addr)));
  assign rt_busy = (rt_addr != 5'd0) & (rt_hit | (wr_en_q & (wr_addr_q == rt_addr)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_pc_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_pc_q   <= wr_pc_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_pc   = wr_pc_q;
  assign count   = cnt_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: per-cycle vector table with a posedge-side scoreboard, plus a mid-burst reset sequence.
module tb_grf_wb_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid, b_valid, b_ready;
  logic [4:0]  w_addr, b_addr, rs_addr, rt_addr, wr_addr;
  logic [31:0] w_data, w_pc, b_data, b_pc, wr_data, wr_pc;
  logic        wr_en, rs_busy, rt_busy;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_addr(w_addr), .w_data(w_data), .w_pc(w_pc),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data), .b_pc(b_pc),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .count(count)
  );

  typedef struct {
    int          id;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        een;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        efb;
    logic [2:0]  ecnt;
    logic        erdy;
    logic        ers;
    logic        ert;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  vec_t mon_e;

  function automatic vec_t mk(logic wv, logic [4:0] wa, logic [31:0] wd,
                              logic bv, logic [4:0] ba, logic [31:0] bd,
                              logic [4:0] rs, logic [4:0] rt,
                              logic een, logic [4:0] ea, logic [31:0] ed, logic efb,
                              logic [2:0] ecnt, logic erdy, logic ers, logic ert);
    vec_t v;
    v.id = 0;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.rs = rs; v.rt = rt;
    v.een = een; v.ea = ea; v.ed = ed; v.efb = efb;
    v.ecnt = ecnt; v.erdy = erdy; v.ers = ers; v.ert = ert;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    w_valid = v.wv; w_addr = v.wa; w_data = v.wd; w_pc = 32'h1000_0000 + v.wd;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd; b_pc = 32'h2000_0000 + v.bd;
    rs_addr = v.rs; rt_addr = v.rt;
  endtask

  // Expectations are queued when a vector is driven and checked just after the edge it targets.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk($sformatf("v%0d wr_en", mon_e.id), wr_en, mon_e.een);
      if (mon_e.een) begin
        chk($sformatf("v%0d wr_addr", mon_e.id), wr_addr, mon_e.ea);
        chk($sformatf("v%0d wr_data", mon_e.id), wr_data, mon_e.ed);
        chk($sformatf("v%0d wr_pc", mon_e.id), wr_pc,
            (mon_e.efb ? 32'h2000_0000 : 32'h1000_0000) + mon_e.ed);
      end
      chk($sformatf("v%0d count", mon_e.id), count, mon_e.ecnt);
      chk($sformatf("v%0d b_ready", mon_e.id), b_ready, mon_e.erdy);
      chk($sformatf("v%0d rs_busy", mon_e.id), rs_busy, mon_e.ers);
      chk($sformatf("v%0d rt_busy", mon_e.id), rt_busy, mon_e.ert);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    w_valid = 1'b0; w_addr = '0; w_data = '0; w_pc = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0; b_pc = '0;
    rs_addr = 5'd5; rt_addr = 5'd3;

    //                 wv wa  wd            bv ba  bd            rs  rt   een ea  ed           fb cnt rdy rs rt
    // W write then a discarded W write to r0
    vecs.push_back(mk(1, 5,  32'h11111111, 0, 0,  32'h0,        5,  0,   1,  5,  32'h11111111, 0, 0, 1, 1, 0));
    vecs.push_back(mk(1, 0,  32'hFFFFFFFF, 0, 0,  32'h0,        5,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        0,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    // fill the FIFO while W holds the port
    vecs.push_back(mk(1, 3,  32'h33,       1, 8,  32'hA0,       8,  3,   1,  3,  32'h33,       0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 3,  32'h33,       1, 9,  32'hA1,       9,  3,   1,  3,  32'h33,       0, 2, 1, 1, 1));
    vecs.push_back(mk(1, 3,  32'h33,       1, 10, 32'hA2,       10, 11,  1,  3,  32'h33,       0, 3, 1, 1, 0));
    vecs.push_back(mk(1, 3,  32'h33,       1, 11, 32'hA3,       11, 8,   1,  3,  32'h33,       0, 4, 0, 1, 1));
    vecs.push_back(mk(1, 3,  32'h33,       1, 12, 32'hBAD,      12, 11,  1,  3,  32'h33,       0, 4, 0, 0, 1));
    // full: the pop at this edge must not admit the offered B request
    vecs.push_back(mk(0, 0,  32'h0,        1, 13, 32'hDD,       8,  11,  1,  8,  32'hA0,       1, 3, 1, 1, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        8,  13,  1,  9,  32'hA1,       1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        10, 11,  1,  10, 32'hA2,       1, 1, 1, 1, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        10, 11,  1,  11, 32'hA3,       1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        10, 11,  0,  0,  32'h0,        0, 0, 1, 0, 0));
    // queued r7 squashed by a younger W write to r7
    vecs.push_back(mk(1, 1,  32'h01,       1, 7,  32'hB7,       7,  1,   1,  1,  32'h01,       0, 1, 1, 1, 1));
    vecs.push_back(mk(1, 7,  32'hC7,       0, 0,  32'h0,        7,  1,   1,  7,  32'hC7,       0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        7,  1,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        7,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    // same-cycle W and B to r4: B is newer and survives
    vecs.push_back(mk(1, 4,  32'h44,       1, 4,  32'h55,       4,  0,   1,  4,  32'h44,       0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        4,  0,   1,  4,  32'h55,       1, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        4,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    // busy on queued r12, then squashed by W
    vecs.push_back(mk(1, 2,  32'h22,       1, 12, 32'hC12,      12, 0,   1,  2,  32'h22,       0, 1, 1, 1, 0));
    vecs.push_back(mk(1, 12, 32'h12C,      0, 0,  32'h0,        12, 0,   1,  12, 32'h12C,      0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        12, 0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    // B write to r0 is accepted but never enqueued
    vecs.push_back(mk(0, 0,  32'h0,        1, 0,  32'hDEAD,     0,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0,  32'h0,        0, 0,  32'h0,        0,  0,   0,  0,  32'h0,        0, 0, 1, 0, 0));

    repeat (2) @(negedge clk);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst wr_pc", wr_pc, 0);
    chk("rst count", count, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst rs_busy", rs_busy, 0);
    chk("rst rt_busy", rt_busy, 0);

    reset = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      vecs[i].id = i;
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(negedge clk);
    end
    chk("scoreboard drained", exp_q.size(), 0);

    // mid-burst reset with three entries queued behind W traffic
    w_valid = 1'b1; w_addr = 5'd3; w_data = 32'h33; w_pc = 32'h1000_0033;
    rs_addr = 5'd20; rt_addr = 5'd0;
    for (int k = 0; k < 3; k++) begin
      b_valid = 1'b1; b_addr = 5'(20 + k); b_data = 32'h20 + k; b_pc = 32'h2000_0020 + k;
      @(negedge clk);
    end
    b_valid = 1'b0;
    chk("pre-reset count", count, 3);
    chk("pre-reset wr_en", wr_en, 1);
    chk("pre-reset rs_busy", rs_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("async reset wr_en", wr_en, 0);
    chk("async reset count", count, 0);
    chk("async reset b_ready", b_ready, 0);
    chk("async reset rs_busy", rs_busy, 0);
    w_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post-reset cycle %0d wr_en", k), wr_en, 0);
    end
    chk("post-reset count", count, 0);
    chk("post-reset b_ready", b_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
